// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer.
// Samples the MEM-stage exception flags and the CP0 registers, with write-back
// forwarding applied. Resolves priority and writes EPC/Status/Cause for one
// cycle. It then issues a one-cycle flush that redirects to the exception
// vector, or to EPC for eret. All outputs come straight from registers.
module cp0_exc_ctrl #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(32'h00000020)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid_i,
    input  logic [31:0]       exc_type_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              in_delay_slot_i,
    input  logic [DATA_W-1:0] cp0_status_i,
    input  logic [DATA_W-1:0] cp0_cause_i,
    input  logic [DATA_W-1:0] cp0_epc_i,
    input  logic              wb_cp0_we_i,
    input  logic [4:0]        wb_cp0_waddr_i,
    input  logic [DATA_W-1:0] wb_cp0_data_i,
    output logic              busy_o,
    output logic              epc_we_o,
    output logic [DATA_W-1:0] epc_o,
    output logic              status_we_o,
    output logic [DATA_W-1:0] status_o,
    output logic              cause_we_o,
    output logic [4:0]        cause_exccode_o,
    output logic              cause_bd_o,
    output logic              flush_o,
    output logic [DATA_W-1:0] new_pc_o,
    output logic [31:0]       excepttype_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] EXL_MASK = {{(DATA_W-2){1'b0}}, 2'b10};
    localparam logic [4:0]        ADDR_STATUS = 5'd12;
    localparam logic [4:0]        ADDR_CAUSE  = 5'd13;
    localparam logic [4:0]        ADDR_EPC    = 5'd14;

    state_t            state_q, state_d;
    logic [31:0]       code_q, code_d;
    logic              eret_q, eret_d;
    logic [DATA_W-1:0] epc_lat_q, epc_lat_d;

    logic              busy_q, busy_d;
    logic              epc_we_q, epc_we_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic              status_we_q, status_we_d;
    logic [DATA_W-1:0] status_q, status_d;
    logic              cause_we_q, cause_we_d;
    logic [4:0]        exccode_q, exccode_d;
    logic              bd_q, bd_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] new_pc_q, new_pc_d;
    logic [31:0]       excepttype_q, excepttype_d;

    logic [DATA_W-1:0] eff_status_s, eff_epc_s;
    logic [15:8]       eff_cause_s;
    logic              int_pend_s;
    logic [31:0]       code_s;
    logic [4:0]        exccode_s;
    logic              eret_s;
    logic              event_s;
    logic              unused_s;

    // Only the software-interrupt bits of Cause are writable, hence forwarded.
    assign eff_status_s = (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS) ? wb_cp0_data_i : cp0_status_i;
    assign eff_epc_s    = (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)    ? wb_cp0_data_i : cp0_epc_i;
    assign eff_cause_s  = {cp0_cause_i[15:10],
                           (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE) ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8]};
    assign int_pend_s   = eff_status_s[0] & ~eff_status_s[1] & (|(eff_cause_s & eff_status_s[15:8]));
    assign event_s      = exc_valid_i && (code_s != 32'd0);
    assign unused_s     = ^{exc_type_i[31:13], exc_type_i[7:0], cp0_cause_i[DATA_W-1:16], cp0_cause_i[7:0]};

    // Priority resolution: interrupt > syscall > RI > trap > overflow > eret.
    always_comb begin
        code_s    = 32'd0;
        exccode_s = 5'd0;
        eret_s    = 1'b0;
        if (int_pend_s) begin
            code_s    = 32'd1;
            exccode_s = 5'd0;
        end else if (exc_type_i[8]) begin
            code_s    = 32'd8;
            exccode_s = 5'd8;
        end else if (exc_type_i[9]) begin
            code_s    = 32'd9;
            exccode_s = 5'd10;
        end else if (exc_type_i[10]) begin
            code_s    = 32'd10;
            exccode_s = 5'd13;
        end else if (exc_type_i[11]) begin
            code_s    = 32'd12;
            exccode_s = 5'd12;
        end else if (exc_type_i[12]) begin
            code_s    = 32'd14;
            eret_s    = 1'b1;
        end else begin
            code_s    = 32'd0;
        end
    end

    // Next state, latched event data and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        eret_d       = eret_q;
        epc_lat_d    = epc_lat_q;
        busy_d       = 1'b0;
        epc_we_d     = 1'b0;
        epc_d        = '0;
        status_we_d  = 1'b0;
        status_d     = '0;
        cause_we_d   = 1'b0;
        exccode_d    = 5'd0;
        bd_d         = 1'b0;
        flush_d      = 1'b0;
        new_pc_d     = '0;
        excepttype_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    state_d     = ST_COMMIT;
                    busy_d      = 1'b1;
                    code_d      = code_s;
                    eret_d      = eret_s;
                    epc_lat_d   = eff_epc_s;
                    status_we_d = 1'b1;
                    if (eret_s) begin
                        status_d = eff_status_s & ~EXL_MASK;
                    end else begin
                        status_d   = eff_status_s | EXL_MASK;
                        cause_we_d = 1'b1;
                        exccode_d  = exccode_s;
                        // Nested exceptions keep the original EPC/BD.
                        if (!eff_status_s[1]) begin
                            epc_we_d = 1'b1;
                            if (in_delay_slot_i) begin
                                epc_d = pc_i - DATA_W'(4);
                                bd_d  = 1'b1;
                            end else begin
                                epc_d = pc_i;
                                bd_d  = 1'b0;
                            end
                        end else begin
                            epc_we_d = 1'b0;
                            bd_d     = 1'b0;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d      = ST_FLUSH;
                busy_d       = 1'b1;
                flush_d      = 1'b1;
                new_pc_d     = eret_q ? epc_lat_q : EXC_VECTOR;
                excepttype_d = code_q;
            end
            ST_FLUSH: begin
                state_d   = ST_IDLE;
                code_d    = 32'd0;
                eret_d    = 1'b0;
                epc_lat_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latches and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            code_q       <= 32'd0;
            eret_q       <= 1'b0;
            epc_lat_q    <= '0;
            busy_q       <= 1'b0;
            epc_we_q     <= 1'b0;
            epc_q        <= '0;
            status_we_q  <= 1'b0;
            status_q     <= '0;
            cause_we_q   <= 1'b0;
            exccode_q    <= 5'd0;
            bd_q         <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
            excepttype_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            eret_q       <= eret_d;
            epc_lat_q    <= epc_lat_d;
            busy_q       <= busy_d;
            epc_we_q     <= epc_we_d;
            epc_q        <= epc_d;
            status_we_q  <= status_we_d;
            status_q     <= status_d;
            cause_we_q   <= cause_we_d;
            exccode_q    <= exccode_d;
            bd_q         <= bd_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
            excepttype_q <= excepttype_d;
        end
    end

    assign busy_o          = busy_q;
    assign epc_we_o        = epc_we_q;
    assign epc_o           = epc_q;
    assign status_we_o     = status_we_q;
    assign status_o        = status_q;
    assign cause_we_o      = cause_we_q;
    assign cause_exccode_o = exccode_q;
    assign cause_bd_o      = bd_q;
    assign flush_o         = flush_q;
    assign new_pc_o        = new_pc_q;
    assign excepttype_o    = excepttype_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized scoreboard bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [31:0] exc_type_i = 32'd0;
    logic [31:0] pc_i = 32'd0;
    logic        in_delay_slot_i = 1'b0;
    logic [31:0] cp0_status_i = 32'd0;
    logic [31:0] cp0_cause_i = 32'd0;
    logic [31:0] cp0_epc_i = 32'd0;
    logic        wb_cp0_we_i = 1'b0;
    logic [4:0]  wb_cp0_waddr_i = 5'd0;
    logic [31:0] wb_cp0_data_i = 32'd0;
    logic        busy_o, epc_we_o, status_we_o, cause_we_o, cause_bd_o, flush_o;
    logic [31:0] epc_o, status_o, new_pc_o, excepttype_o;
    logic [4:0]  cause_exccode_o;

    cp0_exc_ctrl #(.DATA_W(32), .EXC_VECTOR(32'h00000020)) dut (
        .clk(clk), .rst(rst),
        .exc_valid_i(exc_valid_i), .exc_type_i(exc_type_i), .pc_i(pc_i),
        .in_delay_slot_i(in_delay_slot_i), .cp0_status_i(cp0_status_i),
        .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i),
        .busy_o(busy_o), .epc_we_o(epc_we_o), .epc_o(epc_o),
        .status_we_o(status_we_o), .status_o(status_o),
        .cause_we_o(cause_we_o), .cause_exccode_o(cause_exccode_o),
        .cause_bd_o(cause_bd_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .excepttype_o(excepttype_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        logic        epc_we;
        logic [31:0] epc;
        logic [31:0] status;
        logic        cause_we;
        logic [4:0]  exc;
        logic        bd;
    } commit_t;

    typedef struct packed {
        int          cyc;
        logic [31:0] npc;
        logic [31:0] et;
    } flush_t;

    commit_t cq[$];
    flush_t  fq[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      ignore_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, epc_we_o, status_we_o, cause_we_o}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        chk({tag, "_values"}, epc_o | status_o | new_pc_o | excepttype_o
                              | {26'd0, cause_exccode_o, cause_bd_o}, 32'd0);
    endtask

    // Drive one cycle of inputs and let the reference model predict the response.
    task automatic drive(input logic v, input logic [31:0] ty, input logic [31:0] pc,
                         input logic ds, input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] ep, input logic we, input logic [4:0] ad,
                         input logic [31:0] wd);
        logic [31:0] es, ec, ee;
        logic [31:0] code;
        logic [4:0]  exc;
        int          bits[5]  = '{8, 9, 10, 11, 12};
        int          codes[5] = '{8, 9, 10, 12, 14};
        int          excs[5]  = '{8, 10, 13, 12, 0};
        commit_t     c;
        flush_t      f;
        exc_valid_i = v; exc_type_i = ty; pc_i = pc; in_delay_slot_i = ds;
        cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
        wb_cp0_we_i = we; wb_cp0_waddr_i = ad; wb_cp0_data_i = wd;
        if (ignore_cnt > 0) begin
            ignore_cnt--;
        end else if (v) begin
            es = (we && ad == 5'd12) ? wd : st;
            ee = (we && ad == 5'd14) ? wd : ep;
            ec = ca;
            if (we && ad == 5'd13) ec[9:8] = wd[9:8];
            code = 32'd0;
            exc = 5'd0;
            if (es[0] && !es[1] && ((ec[15:8] & es[15:8]) != 8'h00)) begin
                code = 32'd1;
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (code == 32'd0 && ty[bits[i]]) begin
                        code = codes[i];
                        exc = excs[i][4:0];
                    end
                end
            end
            if (code != 32'd0) begin
                c.cyc = cyc + 1;
                if (code == 32'd14) begin
                    c.status = es & ~32'h2;
                    c.cause_we = 1'b0; c.exc = 5'd0; c.epc_we = 1'b0; c.epc = 32'd0; c.bd = 1'b0;
                end else begin
                    c.status = es | 32'h2;
                    c.cause_we = 1'b1; c.exc = exc;
                    c.epc_we = !es[1];
                    c.bd = !es[1] && ds;
                    c.epc = ds ? pc - 32'd4 : pc;
                end
                f.cyc = cyc + 2;
                f.npc = (code == 32'd14) ? ee : 32'h20;
                f.et = code;
                cq.push_back(c);
                fq.push_back(f);
                ignore_cnt = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a commit or a flush.
    initial begin
        commit_t c;
        flush_t  f;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (cq.size() > 0 && cq[0].cyc < cyc) begin
                    c = cq.pop_front();
                    chk("commit_missing", 32'(cyc), 32'(c.cyc));
                end
                if (fq.size() > 0 && fq[0].cyc < cyc) begin
                    f = fq.pop_front();
                    chk("flush_missing", 32'(cyc), 32'(f.cyc));
                end
                if (status_we_o || epc_we_o || cause_we_o) begin
                    if (cq.size() == 0) begin
                        chk("commit_spurious", {31'd0, status_we_o}, 32'd0);
                    end else begin
                        c = cq.pop_front();
                        chk("commit_cycle", 32'(cyc), 32'(c.cyc));
                        chk("status_we", {31'd0, status_we_o}, 32'd1);
                        chk("status", status_o, c.status);
                        chk("epc_we", {31'd0, epc_we_o}, {31'd0, c.epc_we});
                        if (c.epc_we) chk("epc", epc_o, c.epc);
                        chk("cause_we", {31'd0, cause_we_o}, {31'd0, c.cause_we});
                        if (c.cause_we) begin
                            chk("exccode", {27'd0, cause_exccode_o}, {27'd0, c.exc});
                            chk("bd", {31'd0, cause_bd_o}, {31'd0, c.bd});
                        end
                        chk("commit_busy", {31'd0, busy_o}, 32'd1);
                    end
                end
                if (flush_o) begin
                    if (fq.size() == 0) begin
                        chk("flush_spurious", {31'd0, flush_o}, 32'd0);
                    end else begin
                        f = fq.pop_front();
                        chk("flush_cycle", 32'(cyc), 32'(f.cyc));
                        chk("new_pc", new_pc_o, f.npc);
                        chk("excepttype", excepttype_o, f.et);
                        chk("flush_busy", {31'd0, busy_o}, 32'd1);
                    end
                end else begin
                    chk("idle_new_pc", new_pc_o, 32'd0);
                    chk("idle_excepttype", excepttype_o, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] st, ty;
        logic        we;
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("reset_hold");
        rst = 1'b1;
        idle(2);

        // Syscall with EXL clear
        drive(1'b1, 32'h100, 32'h100, 1'b0, 32'h10000001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);
        // Overflow in delay slot
        drive(1'b1, 32'h800, 32'h204, 1'b1, 32'h00000001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);
        // Interrupt beats RI
        drive(1'b1, 32'h200, 32'h300, 1'b0, 32'h0000FF01, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);
        // ERET with forwarded EPC
        drive(1'b1, 32'h1000, 32'h400, 1'b0, 32'h00000003, 32'h0, 32'h40, 1'b1, 5'd14, 32'h80);
        idle(3);
        // Nested trap, then a syscall offered while busy
        drive(1'b1, 32'h400, 32'h500, 1'b0, 32'h00000003, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h100, 32'h504, 1'b0, 32'h00000001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h100, 32'h508, 1'b0, 32'h00000001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(2);
        // No detection without exc_valid_i, even with an interrupt pending
        drive(1'b0, 32'h100, 32'h600, 1'b0, 32'h0000FF01, 32'hFF00, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);
        // Interrupt enabled only by forwarded Cause[9:8] / forwarded Status
        drive(1'b1, 32'h0, 32'h700, 1'b0, 32'h00000301, 32'h0, 32'h0, 1'b1, 5'd13, 32'h100);
        idle(3);
        drive(1'b1, 32'h0, 32'h704, 1'b0, 32'h0, 32'h0000FF00, 32'h0, 1'b1, 5'd12, 32'h0000FF01);
        idle(3);
        // Back-to-back syscalls held high: accepted every third cycle
        for (int i = 0; i < 7; i++)
            drive(1'b1, 32'h100, 32'h800 + 32'(4 * i), 1'b0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);

        // Reset during COMMIT
        drive(1'b1, 32'h100, 32'h900, 1'b0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        cq.delete();
        fq.delete();
        ignore_cnt = 0;
        exc_valid_i = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midreset_hold");
        rst = 1'b1;
        idle(3);
        drive(1'b1, 32'h100, 32'hA00, 1'b0, 32'h10000001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            st = $urandom;
            st[1] = ($urandom_range(0, 3) == 0);
            st[15:8] = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
            ty = $urandom;
            ty[12:8] = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            we = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 9) < 7, ty, $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 1) == 1, st, $urandom, $urandom, we,
                  5'($urandom_range(11, 15)), $urandom);
        end
        idle(5);
        chk("commit_queue_empty", 32'(cq.size()), 32'd0);
        chk("flush_queue_empty", 32'(fq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception/interrupt sequencer for the CP0 register file. It samples the MEM-stage exception vector and the current CP0 Status/Cause/EPC, with write-back forwarding applied. It resolves priority and drives the CP0 update strobes (EPC, Status.EXL, Cause.ExcCode/BD). It then issues a one-cycle pipeline flush with the redirect PC, either the exception vector or EPC for ERET.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for all exceptions and interrupts
DATA_W, 32, CP0 register / PC width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
exc_valid_i  input  1  MEM-stage instruction valid this cycle
exc_type_i  input  32  exception flags: [8] syscall, [9] reserved instr, [10] trap, [11] overflow, [12] eret; other bits ignored
pc_i  input  DATA_W  PC of MEM-stage instruction
in_delay_slot_i  input  1  MEM-stage instruction sits in a branch delay slot
cp0_status_i  input  DATA_W  current Status
cp0_cause_i  input  DATA_W  current Cause
cp0_epc_i  input  DATA_W  current EPC
wb_cp0_we_i  input  1  CP0 write in WB stage (forwarding)
wb_cp0_waddr_i  input  5  WB CP0 write address (12 Status, 13 Cause, 14 EPC)
wb_cp0_data_i  input  DATA_W  WB CP0 write data
busy_o  output  1  controller occupied; pipeline must stall MEM and earlier
epc_we_o  output  1  write EPC this cycle
epc_o  output  DATA_W  EPC write value
status_we_o  output  1  write Status this cycle
status_o  output  DATA_W  Status write value
cause_we_o  output  1  write Cause.ExcCode and Cause.BD this cycle
cause_exccode_o  output  5  ExcCode value
cause_bd_o  output  1  BD value
flush_o  output  1  one-cycle pipeline flush
new_pc_o  output  DATA_W  redirect PC, valid while flush_o = 1
excepttype_o  output  32  resolved exception code; 0 = none; 32'h1 interrupt, 8 sys, 9 RI, 10 Tr, 12 Ov, 14 eret

Behaviour:
- Forwarding (combinational):
  - effective Status = wb_cp0_data_i when wb_cp0_we_i=1 and addr=12.
  - effective EPC = wb_cp0_data_i when wb_cp0_we_i=1 and addr=14.
  - effective Cause[9:8] = wb data [9:8] when wb_cp0_we_i=1 and addr=13.
- Interrupt pending = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]), all effective values.
- Detection happens only in IDLE with exc_valid_i=1. Priority: interrupt > syscall > RI > trap > overflow > eret.
  - ExcCodes: Int 0, Sys 8, RI 10, Tr 13, Ov 12.
- FSM states: IDLE, COMMIT, FLUSH.
  - IDLE -> COMMIT at the edge where an event is detected. Latch event, pc_i, in_delay_slot_i and the effective registers.
  - COMMIT, one cycle: registered strobes are high for exactly this cycle.
    - Non-eret event with latched Status.EXL=0: epc_we_o=1. epc_o = pc-4 with cause_bd_o=1 if in delay slot, else epc_o = pc with cause_bd_o=0.
    - Latched Status.EXL=1 (nested): epc_we_o=0 and cause_bd_o=0. Cause and Status are still written.
    - Non-eret: status_we_o=1 with status_o = latched Status | 32'h2; cause_we_o=1 with cause_exccode_o set.
    - eret: status_we_o=1 with status_o = latched Status & ~32'h2. epc_we_o=0, cause_we_o=0.
  - COMMIT -> FLUSH unconditionally.
  - FLUSH, one cycle: flush_o=1 and excepttype_o = latched code. new_pc_o = latched EPC for eret, EXC_VECTOR otherwise.
  - FLUSH -> IDLE.
- busy_o=1 in COMMIT and FLUSH. Inputs are ignored while busy. A new event is accepted no earlier than the first IDLE cycle after FLUSH.
- Latency: detect edge T; CP0 strobes in cycle T+1; flush in T+2; IDLE at T+3.
- exc_valid_i=0: no detection, even with an interrupt pending.
- Reset (rst=0, any time including mid-sequence): state goes to IDLE immediately. All outputs go to 0 (new_pc_o=0, excepttype_o=0), as do all latches. No partial strobe may remain asserted after reset.
- Outputs are registered. new_pc_o and excepttype_o are 0 outside FLUSH.

Test Plan:
- Syscall: pc_i=0x100, exc_type_i[8]=1, Status=0x10000001 -> T+1: epc_o=0x100, status_o=0x10000003, exccode=8, bd=0; T+2: flush_o=1, new_pc_o=0x20, excepttype_o=8.
- Delay-slot overflow: pc_i=0x204, in_delay_slot_i=1, [11]=1 -> epc_o=0x200, bd=1, exccode=12.
- Interrupt vs RI: Status=0x0000FF01, Cause[10]=1, exc_type_i[9]=1 -> exccode=0 (interrupt wins), excepttype_o=1.
- ERET with forwarded EPC: cp0_epc_i=0x40, WB writes addr 14 = 0x80 in the same cycle -> status_we_o=1 clears EXL, epc_we_o=0, flush new_pc_o=0x80.
- Nested: Status.EXL=1, trap -> epc_we_o=0, cause_we_o=1 with exccode=13; a syscall presented during busy is ignored.
- Reset mid-sequence: assert rst=0 during COMMIT -> all strobes and busy_o drop to 0 asynchronously; no flush follows; after release, a new syscall is handled normally.
